// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmit and receive paths.
package uart_pkg;

  // Defaults common to the TX and RX sides.
  localparam int unsigned DefDataWidth  = 8;
  localparam int unsigned DefPrescWidth = 6;

  // Parity type encoding as presented on PAR_TYP.
  localparam logic ParEven = 1'b0;
  localparam logic ParOdd  = 1'b1;

  // Transmit frame sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts CLK cycles 0..P-1 and flags the last cycle of each serial bit.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned PRESC_WIDTH = DefPrescWidth
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic                   en_i,
  input  logic [PRESC_WIDTH-1:0] prescale_i,
  output logic                   bit_done_o
);

  logic [PRESC_WIDTH-1:0] count_q, count_d;
  logic [PRESC_WIDTH-1:0] last_cnt;

  // A prescale of zero behaves as one cycle per bit.
  assign last_cnt   = (prescale_i == '0) ? '0 : prescale_i - PRESC_WIDTH'(1);
  assign bit_done_o = en_i && (count_q == last_cnt);

  // Next count: wrap at period end, hold at zero whenever the transmitter is idle.
  always_comb begin
    count_d = count_q;
    if (clear_i || !en_i) begin
      count_d = '0;
    end else if (bit_done_o) begin
      count_d = '0;
    end else begin
      count_d = count_q + PRESC_WIDTH'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned PRESC_WIDTH = DefPrescWidth
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   Data_Valid,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic [PRESC_WIDTH-1:0] Prescale,
  output logic                   TX_OUT,
  output logic                   Busy
);

  localparam int unsigned     CntW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  tx_state_e              state_q, state_d;
  logic [DATA_WIDTH-1:0]  data_q;
  logic                   par_en_q;
  logic                   par_typ_q;
  logic [PRESC_WIDTH-1:0] presc_q;
  logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   accept;
  logic                   bit_done;

  assign accept = (state_q == StIdle) && Data_Valid;
  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

  // busy_q mirrors state_q != StIdle, so it doubles as the timer enable.
  uart_tx_bit_timer #(
    .PRESC_WIDTH(PRESC_WIDTH)
  ) u_bit_timer (
    .clk_i     (CLK),
    .rst_i     (RST),
    .clear_i   (accept),
    .en_i      (busy_q),
    .prescale_i(presc_q),
    .bit_done_o(bit_done)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and data bit index; both advance only at a bit-period end.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      StIdle: begin
        bit_cnt_d = '0;
        if (Data_Valid) state_d = StStart;
      end
      StStart: begin
        if (bit_done) state_d = StData;
      end
      StData: begin
        if (bit_done) begin
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
      end
      StParity: begin
        if (bit_done) state_d = StStop;
      end
      StStop: begin
        if (bit_done) state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Output decode from the next state so TX_OUT and Busy come straight from flops.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != StIdle);
    unique case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = data_q[bit_cnt_d];
      StParity: tx_d = (^data_q) ^ (par_typ_q == ParOdd);
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // Output and bit-counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Frame configuration captured at acceptance, frozen for the whole frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= ParEven;
      presc_q   <= '0;
    end else if (accept) begin
      data_q    <= P_DATA;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
      presc_q   <= Prescale;
    end
  end

endmodule
